// File: rtl/fetch_unit.sv
// Instruction-fetch initiator: issues single-outstanding reads to the instruction
// RAM, queues returned words with their PCs, and hands them to decode.
module fetch_unit #(
  parameter int          fifo_depth = 4,
  parameter logic [31:0] reset_pc   = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_instr,
  output logic        iram_valid,
  output logic        iram_instr,
  output logic [31:0] iram_addr,
  output logic [31:0] iram_wdata,
  output logic [3:0]  iram_wstrb,
  input  logic [31:0] iram_rdata,
  input  logic        iram_ready
);

  localparam int AW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam logic [AW:0] DEPTH = (AW+1)'(fifo_depth);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t        state_q;
  logic [31:0]   next_pc_q;
  logic [31:0]   addr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW:0]   count_q;
  logic [31:0]   pc_mem_q    [fifo_depth];
  logic [31:0]   instr_mem_q [fifo_depth];

  logic        issue;
  logic        push;
  logic        pop;
  logic [AW:0] occupancy;
  logic        unused_pc_lsbs;

  assign unused_pc_lsbs = ^redirect_pc[1:0];

  // The word still in flight in WAIT is reserved against the buffer; a
  // same-cycle dequeue is not credited.
  assign occupancy = count_q + ((state_q == WAIT) ? (AW+1)'(1) : (AW+1)'(0));
  assign issue     = rst && !redirect && ((state_q == IDLE) || iram_ready)
                     && (occupancy < DEPTH);
  assign push      = (state_q == WAIT) && iram_ready && !redirect;
  assign pop       = fetch_valid && fetch_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      next_pc_q <= reset_pc;
      addr_q    <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      for (int i = 0; i < fifo_depth; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else if (redirect) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      next_pc_q <= {redirect_pc[31:2], 2'b00};
      case (state_q)
        WAIT:    state_q <= iram_ready ? IDLE : DROP;
        DROP:    if (iram_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end else begin
      if (issue) begin
        addr_q    <= next_pc_q;
        next_pc_q <= next_pc_q + 32'd4;
        state_q   <= WAIT;
      end else if (iram_ready && (state_q != IDLE)) begin
        state_q <= IDLE;
      end
      if (push) begin
        pc_mem_q[wr_ptr_q]    <= addr_q;
        instr_mem_q[wr_ptr_q] <= iram_rdata;
        wr_ptr_q              <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign iram_valid  = issue;
  assign iram_addr   = issue ? next_pc_q : addr_q;
  assign iram_instr  = 1'b1;
  assign iram_wdata  = 32'h0;
  assign iram_wstrb  = 4'h0;
  assign fetch_valid = (count_q != '0);
  assign fetch_pc    = pc_mem_q[rd_ptr_q];
  assign fetch_instr = instr_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run against an
// address-sequence reference model with a variable-latency RAM.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, redirect, fetch_ready, iram_ready;
  logic [31:0] redirect_pc, iram_rdata;
  logic        fetch_valid, iram_valid, iram_instr;
  logic [31:0] fetch_pc, fetch_instr, iram_addr, iram_wdata;
  logic [3:0]  iram_wstrb;

  always #5 clk = ~clk;

  fetch_unit #(.fifo_depth(4), .reset_pc(32'h100)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_pc(fetch_pc),
    .fetch_instr(fetch_instr), .iram_valid(iram_valid), .iram_instr(iram_instr),
    .iram_addr(iram_addr), .iram_wdata(iram_wdata), .iram_wstrb(iram_wstrb),
    .iram_rdata(iram_rdata), .iram_ready(iram_ready)
  );

  int n_chk = 0;
  int n_pass = 0;

  // RAM responder state (used when ram_auto is set)
  bit          ram_auto = 1'b0;
  bit          ram_pend = 1'b0;
  int          ram_cnt = 0;
  int          lat_min = 1, lat_max = 1;
  logic [31:0] ram_addr = '0;

  // Observations of the cycle most recently stepped
  logic        o_iv, o_fv, o_pend;
  logic [31:0] o_ia, o_fpc, o_fin;

  function automatic logic [31:0] ramf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0DE_5A5A;
  endfunction

  task automatic step();
    #2;
    o_iv = iram_valid; o_ia = iram_addr; o_fv = fetch_valid;
    o_fpc = fetch_pc; o_fin = fetch_instr; o_pend = ram_pend;
    if (ram_auto && iram_valid) begin
      ram_pend = 1'b1; ram_addr = iram_addr;
      ram_cnt = int'($urandom_range(lat_max, lat_min));
    end
    @(posedge clk); #1;
    if (ram_auto) begin
      iram_ready = 1'b0;
      if (ram_pend) begin
        ram_cnt--;
        if (ram_cnt == 0) begin
          iram_ready = 1'b1; iram_rdata = ramf(ram_addr); ram_pend = 1'b0;
        end
      end
    end
  endtask

  task automatic do_reset();
    ram_pend = 1'b0; iram_ready = 1'b0; redirect = 1'b0; rst = 1'b0;
    step(); step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; redirect = 1'b0; redirect_pc = '0; fetch_ready = 1'b0;
    iram_ready = 1'b0; iram_rdata = '0; ram_auto = 1'b0;
    step(); step();
    n_chk++; if (o_iv !== 1'b0) $display("FAIL reset_iram_valid got=%0b exp=0", o_iv); else n_pass++;
    n_chk++; if (o_ia !== 32'h0) $display("FAIL reset_iram_addr got=%h exp=0", o_ia); else n_pass++;
    n_chk++; if (o_fv !== 1'b0) $display("FAIL reset_fetch_valid got=%0b exp=0", o_fv); else n_pass++;
    n_chk++; if (o_fpc !== 32'h0) $display("FAIL reset_fetch_pc got=%h exp=0", o_fpc); else n_pass++;
    n_chk++; if (o_fin !== 32'h0) $display("FAIL reset_fetch_instr got=%h exp=0", o_fin); else n_pass++;
    n_chk++; if ({iram_instr, iram_wdata, iram_wstrb} !== {1'b1, 32'h0, 4'h0})
      $display("FAIL const_outputs got=%b/%h/%h exp=1/0/0", iram_instr, iram_wdata, iram_wstrb); else n_pass++;
  endtask

  task automatic test_streaming();
    ram_auto = 1'b1; lat_min = 1; lat_max = 1; fetch_ready = 1'b1; rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      logic [31:0] pc;
      step();
      n_chk++; if (o_iv !== 1'b1 || o_ia !== 32'h100 + 32'(4*k))
        $display("FAIL stream_req k=%0d got=%0b/%h exp=1/%h", k, o_iv, o_ia, 32'h100 + 32'(4*k)); else n_pass++;
      if (k < 2) begin
        n_chk++; if (o_fv !== 1'b0) $display("FAIL stream_early_valid k=%0d got=%0b exp=0", k, o_fv); else n_pass++;
      end else begin
        pc = 32'h100 + 32'(4*(k-2));
        n_chk++; if (o_fv !== 1'b1 || o_fpc !== pc || o_fin !== ramf(pc))
          $display("FAIL stream_head k=%0d got=%0b/%h/%h exp=1/%h/%h", k, o_fv, o_fpc, o_fin, pc, ramf(pc)); else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure();
    int nreq = 0;
    logic [31:0] last = '0;
    do_reset();
    ram_auto = 1'b1; lat_min = 1; lat_max = 1; fetch_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (o_iv) begin nreq++; last = o_ia; end
    end
    n_chk++; if (nreq != 4 || last !== 32'h10C) $display("FAIL bp_fill_reqs got=%0d/%h exp=4/0000010c", nreq, last); else n_pass++;
    n_chk++; if (o_fv !== 1'b1 || o_fpc !== 32'h100) $display("FAIL bp_head got=%0b/%h exp=1/00000100", o_fv, o_fpc); else n_pass++;
    fetch_ready = 1'b1;
    step();
    n_chk++; if (o_iv !== 1'b0) $display("FAIL bp_no_credit got=%0b exp=0", o_iv); else n_pass++;
    fetch_ready = 1'b0; nreq = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (o_iv) begin nreq++; last = o_ia; end
    end
    n_chk++; if (nreq != 1 || last !== 32'h110) $display("FAIL bp_refill got=%0d/%h exp=1/00000110", nreq, last); else n_pass++;
    n_chk++; if (o_fv !== 1'b1 || o_fpc !== 32'h104) $display("FAIL bp_head2 got=%0b/%h exp=1/00000104", o_fv, o_fpc); else n_pass++;
  endtask

  task automatic test_redirect_inflight();
    bit got_req = 0, got_fetch = 0, saw_old = 0;
    logic [31:0] first_req = '0, first_pc = '0, first_in = '0;
    do_reset();
    ram_auto = 1'b1; lat_min = 3; lat_max = 3; fetch_ready = 1'b1;
    step();
    n_chk++; if (o_iv !== 1'b1 || o_ia !== 32'h100) $display("FAIL rdi_first_req got=%0b/%h exp=1/00000100", o_iv, o_ia); else n_pass++;
    redirect = 1'b1; redirect_pc = 32'h203;
    step();
    n_chk++; if (o_iv !== 1'b0) $display("FAIL rdi_no_issue got=%0b exp=0", o_iv); else n_pass++;
    redirect = 1'b0;
    for (int k = 0; k < 14 && !got_fetch; k++) begin
      step();
      if (o_iv && !got_req) begin got_req = 1; first_req = o_ia; end
      if (o_fv) begin
        if (o_fpc === 32'h100) saw_old = 1;
        got_fetch = 1; first_pc = o_fpc; first_in = o_fin;
      end
    end
    n_chk++; if (!got_req || first_req !== 32'h200) $display("FAIL rdi_new_req got=%0b/%h exp=1/00000200", got_req, first_req); else n_pass++;
    n_chk++; if (!got_fetch || saw_old || first_pc !== 32'h200 || first_in !== ramf(32'h200))
      $display("FAIL rdi_first_fetch got=%0b/%h/%h exp=1/00000200/%h", got_fetch, first_pc, first_in, ramf(32'h200)); else n_pass++;
  endtask

  task automatic test_redirect_ready();
    do_reset();
    ram_auto = 1'b0; fetch_ready = 1'b1;
    step();
    redirect = 1'b1; redirect_pc = 32'h300; iram_ready = 1'b1; iram_rdata = ramf(32'h100);
    step();
    n_chk++; if (o_iv !== 1'b0) $display("FAIL rdr_no_issue got=%0b exp=0", o_iv); else n_pass++;
    redirect = 1'b0; iram_ready = 1'b0;
    step();
    n_chk++; if (o_fv !== 1'b0) $display("FAIL rdr_discard got=%0b exp=0", o_fv); else n_pass++;
    n_chk++; if (o_iv !== 1'b1 || o_ia !== 32'h300) $display("FAIL rdr_new_req got=%0b/%h exp=1/00000300", o_iv, o_ia); else n_pass++;
    iram_ready = 1'b1; iram_rdata = ramf(32'h300);
    step();
    iram_ready = 1'b0;
    step();
    n_chk++; if (o_fv !== 1'b1 || o_fpc !== 32'h300 || o_fin !== ramf(32'h300))
      $display("FAIL rdr_fetch got=%0b/%h/%h exp=1/00000300/%h", o_fv, o_fpc, o_fin, ramf(32'h300)); else n_pass++;
  endtask

  task automatic test_full_pushpop();
    logic [31:0] pc;
    do_reset();
    ram_auto = 1'b0; fetch_ready = 1'b0;
    step();
    for (int k = 0; k < 3; k++) begin
      iram_ready = 1'b1; iram_rdata = ramf(32'h100 + 32'(4*k));
      step();
    end
    n_chk++; if (o_iv !== 1'b1 || o_ia !== 32'h10C) $display("FAIL full_req3 got=%0b/%h exp=1/0000010c", o_iv, o_ia); else n_pass++;
    iram_ready = 1'b0;
    step();
    n_chk++; if (o_iv !== 1'b0 || o_fv !== 1'b1) $display("FAIL full_wait got=%0b/%0b exp=0/1", o_iv, o_fv); else n_pass++;
    fetch_ready = 1'b1; iram_ready = 1'b1; iram_rdata = ramf(32'h10C);
    step();
    n_chk++; if (o_iv !== 1'b0 || o_fpc !== 32'h100) $display("FAIL full_pushpop got=%0b/%h exp=0/00000100", o_iv, o_fpc); else n_pass++;
    iram_ready = 1'b0;
    step();
    n_chk++; if (o_iv !== 1'b1 || o_ia !== 32'h110) $display("FAIL full_reissue got=%0b/%h exp=1/00000110", o_iv, o_ia); else n_pass++;
    for (int k = 1; k < 4; k++) begin
      pc = 32'h100 + 32'(4*k);
      if (k > 1) step();
      n_chk++; if (o_fv !== 1'b1 || o_fpc !== pc || o_fin !== ramf(pc))
        $display("FAIL full_order k=%0d got=%0b/%h/%h exp=1/%h/%h", k, o_fv, o_fpc, o_fin, pc, ramf(pc)); else n_pass++;
    end
    step();
    n_chk++; if (o_fv !== 1'b0) $display("FAIL full_drained got=%0b exp=0", o_fv); else n_pass++;
  endtask

  task automatic test_wrap_reset();
    int nreq = 0;
    logic [31:0] reqs [2];
    do_reset();
    ram_auto = 1'b1; lat_min = 1; lat_max = 1; fetch_ready = 1'b1;
    step();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    for (int k = 0; k < 6 && nreq < 2; k++) begin
      step();
      if (o_iv) begin reqs[nreq] = o_ia; nreq++; end
    end
    n_chk++; if (nreq != 2 || reqs[0] !== 32'hFFFF_FFFC || reqs[1] !== 32'h0)
      $display("FAIL wrap_reqs got=%0d/%h/%h exp=2/fffffffc/00000000", nreq, reqs[0], reqs[1]); else n_pass++;
    ram_auto = 1'b0; ram_pend = 1'b0; iram_ready = 1'b0; rst = 1'b0;
    step();
    n_chk++; if (o_iv !== 1'b0) $display("FAIL midreset_valid got=%0b exp=0", o_iv); else n_pass++;
    rst = 1'b1; iram_ready = 1'b1; iram_rdata = 32'hDEAD_BEEF;
    step();
    n_chk++; if (o_iv !== 1'b1 || o_ia !== 32'h100) $display("FAIL postreset_req got=%0b/%h exp=1/00000100", o_iv, o_ia); else n_pass++;
    iram_rdata = ramf(32'h100);
    step();
    iram_ready = 1'b0; fetch_ready = 1'b0;
    step();
    n_chk++; if (o_fv !== 1'b1 || o_fpc !== 32'h100 || o_fin !== ramf(32'h100))
      $display("FAIL stale_ignored got=%0b/%h/%h exp=1/00000100/%h", o_fv, o_fpc, o_fin, ramf(32'h100)); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] exp_req = 32'h100, exp_fetch = 32'h100, tgt;
    bit prev_red = 0, cur_red, cur_fr;
    int ndeq = 0;
    do_reset();
    ram_auto = 1'b1; lat_min = 1; lat_max = 3;
    for (int c = 0; c < 500; c++) begin
      cur_red = ($urandom_range(15, 0) == 0);
      cur_fr  = ($urandom_range(2, 0) != 0);
      tgt = $urandom;
      redirect = cur_red; redirect_pc = tgt; fetch_ready = cur_fr;
      step();
      if (cur_red) begin
        n_chk++; if (o_iv !== 1'b0) $display("FAIL rnd_issue_on_redirect c=%0d got=%0b exp=0", c, o_iv); else n_pass++;
      end else if (o_iv === 1'b1) begin
        n_chk++; if (o_ia !== exp_req || o_pend !== 1'b0)
          $display("FAIL rnd_req c=%0d got=%h/pend%0b exp=%h/pend0", c, o_ia, o_pend, exp_req); else n_pass++;
        exp_req += 32'd4;
      end
      if (prev_red) begin
        n_chk++; if (o_fv !== 1'b0) $display("FAIL rnd_flush c=%0d got=%0b exp=0", c, o_fv); else n_pass++;
      end
      if (o_fv === 1'b1 && cur_fr) begin
        n_chk++; if (o_fpc !== exp_fetch || o_fin !== ramf(exp_fetch))
          $display("FAIL rnd_fetch c=%0d got=%h/%h exp=%h/%h", c, o_fpc, o_fin, exp_fetch, ramf(exp_fetch)); else n_pass++;
        exp_fetch += 32'd4; ndeq++;
      end
      if (cur_red) begin
        exp_req = {tgt[31:2], 2'b00}; exp_fetch = {tgt[31:2], 2'b00};
      end
      prev_red = cur_red;
    end
    redirect = 1'b0;
    n_chk++; if (ndeq < 50) $display("FAIL rnd_progress got=%0d exp>=50", ndeq); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_ready();
    test_full_pushpop();
    test_wrap_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch initiator for the core.
- Drives the instruction RAM request/response interface (valid/instr/addr/wdata/wstrb out, rdata/ready in) as the requesting end.
- Buffers returned words with their PCs in a small FIFO and presents them to decode through a valid/ready handshake.
- Supports pipeline redirects (branch/jump/trap) that flush buffered and in-flight fetches.

Parameters:
- fifo_depth, 4, instruction buffer entries; power of two, ≥2.
- reset_pc, 32'h0, first fetch address after reset.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous active-low reset (rst==0 resets on clk edge).
- redirect  input  1  flush and restart fetch at redirect_pc.
- redirect_pc  input  32  new fetch address; bits [1:0] ignored (treated as 0).
- fetch_valid  output  1  FIFO head holds a valid instruction.
- fetch_ready  input  1  decode accepts head this cycle.
- fetch_pc  output  32  PC of head entry.
- fetch_instr  output  32  instruction word of head entry.
- iram_valid  output  1  request strobe, one-cycle pulse per request.
- iram_instr  output  1  constant 1.
- iram_addr  output  32  word-aligned request address.
- iram_wdata  output  32  constant 0.
- iram_wstrb  output  4  constant 0 (read-only).
- iram_rdata  input  32  response data, valid when iram_ready==1.
- iram_ready  input  1  response strobe.

Behaviour:
- Protocol:
  - Each request is iram_valid high for exactly one cycle.
  - The response is the next cycle with iram_ready==1; latency ≥1 cycle, unbounded.
  - At most one request outstanding.
  - A new request may issue in the same cycle the previous response arrives, so throughput is 1 word/cycle with a 1-cycle RAM.
- Registers: next_pc, FIFO (pc, instr) × fifo_depth with rd/wr pointers and count (0..fifo_depth), state.
- States:
  - IDLE: nothing outstanding.
  - WAIT: outstanding, response to be kept.
  - DROP: outstanding, response to be discarded.
- Issue condition (iram_valid=1 this cycle): !redirect && (state==IDLE || iram_ready) && (count + (state==WAIT ? 1 : 0)) < fifo_depth.
  - Same-cycle dequeue is not credited (conservative).
  - On issue: iram_addr=next_pc; next_pc += 4 (wraps modulo 2^32); state→WAIT.
- Response in WAIT with iram_ready: push {pc of request, iram_rdata} into FIFO; state→IDLE unless a new request issues.
- Response in DROP with iram_ready: data discarded; state→IDLE or WAIT per issue rule.
- iram_ready in IDLE (stale, e.g. after reset or redirect): ignored.
- Redirect (highest priority):
  - FIFO flushed: count=0, pointers reset, so fetch_valid=0 next cycle.
  - next_pc=redirect_pc & ~3.
  - No issue that cycle.
  - WAIT without iram_ready→DROP; WAIT with iram_ready→IDLE, response discarded; DROP stays DROP unless iram_ready (→IDLE).
  - First fetch at the new PC issues no earlier than the next cycle.
  - A dequeue in the redirect cycle still completes from decode's view; the FIFO is emptied regardless.
- FIFO:
  - fetch_valid = (count != 0); fetch_pc/fetch_instr = head entry, combinational from storage.
  - Dequeue when fetch_valid && fetch_ready.
  - Push and dequeue in the same cycle leave count unchanged; pointers wrap modulo fifo_depth.
  - Push never occurs when full; the issue rule guarantees this.
- Outputs when iram_valid==0: iram_addr holds last value (don't-care); iram_instr=1, iram_wdata=0, iram_wstrb=0 always.
- Reset values: iram_valid=0, iram_addr=0, fetch_valid=0, fetch_pc=0, fetch_instr=0 (storage cleared), next_pc=reset_pc, state=IDLE, count=0.
  - First request issues in the first cycle after rst deasserts.
- Reset mid-operation: outstanding request abandoned; its late response is ignored per the IDLE rule.

Test Plan:
- Streaming: 1-cycle RAM model, reset_pc=0x100, fetch_ready=1 → requests at 0x100,0x104,0x108… on consecutive cycles; fetch_valid from cycle 2 after reset; each fetch_pc matches, instr = RAM content.
- Backpressure: fetch_ready=0, fifo_depth=4 → exactly 4 requests issued, count=4, iram_valid stays 0; one dequeue → exactly one new request at 0x110.
- Redirect in flight: 3-cycle RAM latency, redirect to 0x203 while WAIT → next request addr 0x200; the dropped response is not pushed; first fetch_pc=0x200.
- Simultaneous redirect + iram_ready: redirect=1 and iram_ready=1 in the same cycle → response discarded, FIFO empty, state IDLE, request to the new PC the next cycle.
- Wrap/reset: redirect to 0xFFFFFFFC → requests at 0xFFFFFFFC then 0x00000000; assert rst=0 mid-WAIT then release, with a stale iram_ready after release → ignored; first fetch at reset_pc.
- Full with simultaneous push/pop: count=3, WAIT, fetch_ready=1 and iram_ready=1 → count stays 3, order preserved, no overflow.
